// File: rtl/complex_accum_dump.sv
// Complex I/Q frame accumulator: sums N samples, then rounds, shifts and saturates the sums.
// Results appear two cycles after a frame's last sample. There is no backpressure: iv is accepted every cycle.
module complex_accum_dump #(
  parameter int IN_DW  = 44,
  parameter int LEN_W  = 8,
  parameter int SH_W   = 6,
  parameter int OUT_DW = 18
) (
  input  logic                     iclk,
  input  logic                     iresetn,
  input  logic                     iv,
  input  logic [IN_DW-1:0]         ic_i,
  input  logic [IN_DW-1:0]         ic_q,
  input  logic [LEN_W-1:0]         ilen,
  input  logic [SH_W-1:0]          ishift,
  input  logic                     iflush,
  output logic                     ov,
  output logic [OUT_DW-1:0]        od_i,
  output logic [OUT_DW-1:0]        od_q,
  output logic                     osat
);

  localparam int AW = IN_DW + LEN_W;
  localparam logic [SH_W-1:0] SH_MAX = SH_W'(AW - 1);
  localparam logic signed [AW:0] OMAX = (AW+1)'((64'sd1 <<< (OUT_DW - 1)) - 64'sd1);
  localparam logic signed [AW:0] OMIN = -OMAX - (AW+1)'(1);

  typedef enum logic {IDLE, ACC} state_t;

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [SH_W-1:0]         sh_q, sh_d;
  logic signed [AW-1:0]    acc_re_q, acc_re_d;
  logic signed [AW-1:0]    acc_im_q, acc_im_d;
  logic                    dump_q, dump_d;
  logic                    ov_q, ov_d;
  logic [OUT_DW-1:0]       od_re_q, od_re_d;
  logic [OUT_DW-1:0]       od_im_q, od_im_d;
  logic                    osat_q, osat_d;

  logic signed [AW-1:0]    ext_re, ext_im;
  logic                    first;
  logic [LEN_W-1:0]        n_eff, cnt_n;
  logic [OUT_DW:0]         rs_re, rs_im;

  assign ext_re = {{LEN_W{ic_i[IN_DW-1]}}, ic_i};
  assign ext_im = {{LEN_W{ic_q[IN_DW-1]}}, ic_q};

  // Returns {clipped, value}; one extra bit keeps the rounding add from overflowing.
  function automatic logic [OUT_DW:0] rnd_sat(input logic signed [AW-1:0] a,
                                              input logic [SH_W-1:0] sh);
    logic signed [AW:0] w;
    w = {a[AW-1], a};
    if (sh != '0) w = w + ((AW+1)'(1) << (sh - SH_W'(1)));
    w = w >>> sh;
    if (w > OMAX)      return {1'b1, OMAX[OUT_DW-1:0]};
    else if (w < OMIN) return {1'b1, OMIN[OUT_DW-1:0]};
    else               return {1'b0, w[OUT_DW-1:0]};
  endfunction

  assign rs_re = rnd_sat(acc_re_q, sh_q);
  assign rs_im = rnd_sat(acc_im_q, sh_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    sh_d     = sh_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    dump_d   = 1'b0;
    first    = (state_q == IDLE);
    n_eff    = first ? ((ilen == '0) ? LEN_W'(1) : ilen) : len_q;
    cnt_n    = first ? LEN_W'(1) : cnt_q + LEN_W'(1);

    if (iflush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (iv) begin
      if (first) begin
        len_d    = n_eff;
        sh_d     = (ishift > SH_MAX) ? SH_MAX : ishift;
        acc_re_d = ext_re;
        acc_im_d = ext_im;
      end else begin
        acc_re_d = acc_re_q + ext_re;
        acc_im_d = acc_im_q + ext_im;
      end
      if (cnt_n == n_eff) begin
        state_d = IDLE;
        cnt_d   = '0;
        dump_d  = 1'b1;
      end else begin
        state_d = ACC;
        cnt_d   = cnt_n;
      end
    end

    // Output stage reads acc/sh before a back-to-back frame overwrites them at the same edge.
    ov_d    = dump_q;
    od_re_d = od_re_q;
    od_im_d = od_im_q;
    osat_d  = osat_q;
    if (dump_q) begin
      od_re_d = rs_re[OUT_DW-1:0];
      od_im_d = rs_im[OUT_DW-1:0];
      osat_d  = rs_re[OUT_DW] | rs_im[OUT_DW];
    end
  end

  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      sh_q     <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      dump_q   <= 1'b0;
      ov_q     <= 1'b0;
      od_re_q  <= '0;
      od_im_q  <= '0;
      osat_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      sh_q     <= sh_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      dump_q   <= dump_d;
      ov_q     <= ov_d;
      od_re_q  <= od_re_d;
      od_im_q  <= od_im_d;
      osat_q   <= osat_d;
    end
  end

  assign ov   = ov_q;
  assign od_i = od_re_q;
  assign od_q = od_im_q;
  assign osat = osat_q;

endmodule

// File: tb/tb_complex_accum_dump.sv
// Bench for complex_accum_dump: a frame-level reference model feeds a scoreboard that is drained by an independent monitor.
module tb_complex_accum_dump;
  localparam int IN_DW  = 44;
  localparam int LEN_W  = 8;
  localparam int SH_W   = 6;
  localparam int OUT_DW = 18;
  localparam int AW     = IN_DW + LEN_W;
  localparam longint OMAX = (longint'(1) << (OUT_DW - 1)) - 1;
  localparam longint OMIN = -OMAX - 1;

  logic              iclk, iresetn, iv, iflush;
  logic [IN_DW-1:0]  ic_i, ic_q;
  logic [LEN_W-1:0]  ilen;
  logic [SH_W-1:0]   ishift;
  logic              ov, osat;
  logic [OUT_DW-1:0] od_i, od_q;

  complex_accum_dump #(.IN_DW(IN_DW), .LEN_W(LEN_W), .SH_W(SH_W), .OUT_DW(OUT_DW)) dut (
    .iclk(iclk), .iresetn(iresetn), .iv(iv), .ic_i(ic_i), .ic_q(ic_q),
    .ilen(ilen), .ishift(ishift), .iflush(iflush),
    .ov(ov), .od_i(od_i), .od_q(od_q), .osat(osat)
  );

  initial begin
    iclk = 1'b0;
    forever #5 iclk = ~iclk;
  end

  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  typedef struct {
    longint i;
    longint q;
    bit     sat;
    int     cyc;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     failures = 0;

  // Reference model: the open frame is just the list of its samples.
  bit     m_act = 1'b0;
  int     m_n, m_sh;
  longint m_si[$], m_sq[$];

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic void round_sat(input longint a, input int sh, output longint r, output bit s);
    longint t;
    t = a;
    if (sh > 0) t = t + (longint'(1) << (sh - 1));
    t = t >>> sh;
    s = 1'b0;
    if (t > OMAX) begin r = OMAX; s = 1'b1; end
    else if (t < OMIN) begin r = OMIN; s = 1'b1; end
    else r = t;
  endfunction

  task automatic close_frame();
    longint si, sq, ri, rq;
    bit     s_i, s_q;
    exp_t   e;
    si = 0;
    sq = 0;
    foreach (m_si[k]) si += m_si[k];
    foreach (m_sq[k]) sq += m_sq[k];
    round_sat(si, m_sh, ri, s_i);
    round_sat(sq, m_sh, rq, s_q);
    e.i = ri; e.q = rq; e.sat = s_i | s_q; e.cyc = cyc + 2;
    sb.push_back(e);
    m_act = 1'b0;
    m_si.delete();
    m_sq.delete();
  endtask

  task automatic drive(input bit v, input longint i, input longint q,
                       input int len, input int sh, input bit fl);
    @(negedge iclk);
    iv     = v;
    ic_i   = i[IN_DW-1:0];
    ic_q   = q[IN_DW-1:0];
    ilen   = len[LEN_W-1:0];
    ishift = sh[SH_W-1:0];
    iflush = fl;
    if (fl) begin
      m_act = 1'b0;
      m_si.delete();
      m_sq.delete();
    end else if (v) begin
      if (!m_act) begin
        m_act = 1'b1;
        m_n   = (len == 0) ? 1 : len;
        m_sh  = (sh > AW - 1) ? AW - 1 : sh;
      end
      m_si.push_back(i);
      m_sq.push_back(q);
      if (m_si.size() == m_n) close_frame();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic pulse_reset(input int n);
    @(negedge iclk);
    iresetn = 1'b0;
    iv      = 1'b0;
    iflush  = 1'b0;
    sb.delete();
    m_act = 1'b0;
    m_si.delete();
    m_sq.delete();
    repeat (n) @(negedge iclk);
    iresetn = 1'b1;
  endtask

  function automatic longint rand_val();
    int     b;
    longint x;
    b = $urandom_range(IN_DW, 2);
    x = {$urandom, $urandom};
    return x >>> (64 - b);
  endfunction

  // Monitor: independent of stimulus, compares whatever the DUT presents.
  longint last_i = 0, last_q = 0;
  bit     last_sat = 1'b0;
  exp_t   me;

  always @(negedge iclk) begin
    #1;
    if (!iresetn) begin
      chk("rst_ov", longint'(ov), 0);
      chk("rst_od_i", longint'($signed(od_i)), 0);
      chk("rst_od_q", longint'($signed(od_q)), 0);
      chk("rst_osat", longint'(osat), 0);
      last_i = 0; last_q = 0; last_sat = 1'b0;
    end else begin
      while (sb.size() != 0 && sb[0].cyc < cyc) begin
        me = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL missed_ov: got no ov, expected ov at cycle %0d", me.cyc);
      end
      if (ov) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_ov: got ov=1 expected ov=0 (cycle %0d)", cyc);
        end else begin
          me = sb.pop_front();
          chk("ov_cycle", cyc, me.cyc);
          chk("od_i", longint'($signed(od_i)), me.i);
          chk("od_q", longint'($signed(od_q)), me.q);
          chk("osat", longint'(osat), longint'(me.sat));
          last_i = me.i; last_q = me.q; last_sat = me.sat;
        end
      end else begin
        chk("hold_od_i", longint'($signed(od_i)), last_i);
        chk("hold_od_q", longint'($signed(od_q)), last_q);
        chk("hold_osat", longint'(osat), longint'(last_sat));
      end
    end
  end

  initial begin
    iresetn = 1'b1;
    iv = 1'b0; iflush = 1'b0; ic_i = '0; ic_q = '0; ilen = '0; ishift = '0;
    #1 iresetn = 1'b0;
    repeat (3) @(negedge iclk);
    iresetn = 1'b1;

    repeat (4) drive(1'b1, 1, 2, 4, 0, 1'b0);
    idle(3);

    drive(1'b1, 3, -3, 2, 2, 1'b0);
    drive(1'b1, 2, -2, 2, 2, 1'b0);
    idle(3);

    drive(1'b1, 200000, -200000, 1, 0, 1'b0);
    idle(3);

    for (int k = 1; k <= 4; k++) drive(1'b1, k, 0, 2, 0, 1'b0);
    idle(3);

    repeat (2) drive(1'b1, 1, 1, 4, 0, 1'b0);
    drive(1'b1, 1, 1, 4, 0, 1'b1);
    repeat (4) drive(1'b1, 1, 1, 4, 0, 1'b0);
    idle(3);

    repeat (2) drive(1'b1, 7, 7, 3, 0, 1'b0);
    pulse_reset(1);
    drive(1'b1, 5, -5, 0, 0, 1'b0);
    idle(4);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 500 == 0) pulse_reset(1 + $urandom % 2);
      else drive(($urandom % 4) != 0, rand_val(), rand_val(),
                 $urandom % 7, ($urandom % 3 == 0) ? $urandom % 64 : $urandom % 4,
                 ($urandom % 40) == 0);
    end
    idle(5);

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/complex_accum_dump.md
COMPLEX_ACCUM_DUMP -- requirements
Module: complex_accum_dump

Interface
REQ-001 SHALL have parameter IN_DW, default 44, meaning signed width of each input I/Q component (complex multiplier product width).
REQ-002 SHALL have parameter LEN_W, default 8, meaning width of accumulation-length input; accumulator width is IN_DW+LEN_W.
REQ-003 SHALL have parameter SH_W, default 6, meaning width of right-shift control.
REQ-004 SHALL have parameter OUT_DW, default 18, meaning signed width of each output I/Q component.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port iclk, input, 1, meaning the single clock; all logic rising-edge.
REQ-007 SHALL have port iresetn, input, 1, meaning the asynchronous active-low reset.
REQ-008 SHALL have port iv, input, 1, meaning ic_i/ic_q valid this cycle.
REQ-009 SHALL have ports ic_i and ic_q, input, IN_DW, meaning the signed two's-complement I and Q of the product.
REQ-010 SHALL have port ilen, input, LEN_W, meaning samples per frame N; 0 is treated as 1.
REQ-011 SHALL have port ishift, input, SH_W, meaning arithmetic right shift applied at dump; values above IN_DW+LEN_W-1 clamp to IN_DW+LEN_W-1.
REQ-012 SHALL have port iflush, input, 1, meaning synchronous abort of the current frame.
REQ-013 SHALL have port ov, input-to-output direction output, 1, meaning one-cycle dump strobe.
REQ-014 SHALL have ports od_i and od_q, output, OUT_DW, meaning the signed, rounded, saturated frame sums.
REQ-015 SHALL have port osat, output, 1, meaning I or Q saturated in this dump; valid only with ov.

Function
REQ-016 SHALL hold a frame counter with states IDLE (no samples in frame) and ACC (≥1 sample accumulated).
- IDLE->ACC on iv.
- ACC->IDLE on the Nth sample or on iflush.
REQ-017 SHALL latch ilen and ishift on the first sample of each frame; changes mid-frame are ignored until the next frame.
REQ-018 SHALL load the accumulator with the sign-extended sample on the first sample of a frame and add it on subsequent samples; full precision, no internal overflow for N ≤ 2^LEN_W-1.
REQ-019 SHALL, for a sample with iv=1 in cycle t that completes the frame, assert ov=1 for exactly cycle t+2 with od_i/od_q/osat valid.
REQ-020 SHALL round half-up: add 2^(shift-1) when shift>0, then arithmetic right shift by shift.
REQ-021 SHALL saturate each component to [-2^(OUT_DW-1), 2^(OUT_DW-1)-1]; osat=1 if either component clipped.
REQ-022 SHALL accept back-to-back frames: the first sample of frame k+1 may arrive in the cycle after the last sample of frame k, with no bubble and no lost sample.
REQ-023 SHALL give iflush priority over a simultaneous iv: discard that sample, return to IDLE, and produce no ov for the aborted frame; a dump already in the output pipeline still emerges.
REQ-024 SHALL hold od_i/od_q/osat at their last values while ov=0.
REQ-025 SHALL impose no handshake: iv is never back-pressured, and gaps (iv=0) within a frame are allowed.

Reset
REQ-026 SHALL, while iresetn=0, immediately force ov=0, od_i=0, od_q=0 and osat=0, clear the counter and accumulator, and enter IDLE.
REQ-027 SHALL discard a frame in progress when reset is asserted mid-frame, with no ov after release; the first iv after release starts a new frame.

Verification
REQ-028 SHALL check: ilen=4, ishift=0, 4×(1,2) consecutive -> single ov at t_last+2, od=(4,8), osat=0.
REQ-029 SHALL check: ilen=2, ishift=2, samples (3,-3),(2,-2) -> od=(1,-1), osat=0.
REQ-030 SHALL check: ilen=1, ishift=0, sample (200000,-200000) -> od=(131071,-131072), osat=1.
REQ-031 SHALL check: ilen=2, continuous iv, I=1,2,3,4, Q=0 -> two ov pulses 2 cycles apart, od_i=3 then 7.
REQ-032 SHALL check: ilen=4, two samples of (1,1) then iflush with iv=1, then 4×(1,1) -> exactly one ov, od=(4,4).
REQ-033 SHALL check: ilen=3, iresetn low for 1 cycle after 2 samples, then ilen=0, sample (5,-5) -> outputs 0 during reset, then ov with od=(5,-5) two cycles after the sample.
